adder1_seq: RTL
===============

# adder1_seq

Sequential, handshaked counterpart of the combinational chain adder. It accepts a stream of `NUM` unsigned `WIDTH`-bit operands, one per accepted beat, and produces their `SUM_WIDTH`-bit sum on a valid/ready output. It sits at the other end of the operand interface: it consumes the operands serially and delivers the same result the chain adder computes from the packed bus. It is also the sequential design-under-test checked against the chain adder in CEC.

## Interface
- `WIDTH`, default 32: operand width in bits.
- `NUM`, default 16: operands per batch; must be ≥ 1.
- `SUM_WIDTH`, default `WIDTH + $clog2(NUM)`: result width (derived; do not override).
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `in_valid`  input  1  operand beat offered.
- `in_ready`  output  1  block can accept an operand.
- `in_data`  input  `WIDTH`  operand, unsigned.
- `out_valid`  output  1  `out_sum` holds a completed batch sum.
- `out_ready`  input  1  downstream accepts the sum.
- `out_sum`  output  `SUM_WIDTH`  batch sum.
- `busy`  output  1  at least one operand of the current batch has been accepted and the sum is not yet delivered.

## Operation
- **State machine** (states in package enum):
  - `IDLE`: `acc`=0, `cnt`=0, `in_ready`=1. An accepted beat moves to `ACCUM`, or directly to `DONE` when `NUM`==1.
  - `ACCUM`: `in_ready`=1. Each accepted beat updates `acc += zero-extend(in_data)` and `cnt++`. The beat that brings `cnt` to `NUM` moves to `DONE`.
  - `DONE`: `in_ready`=0, `out_valid`=1, `out_sum`=`acc` held stable. When `out_valid && out_ready`, go to `IDLE`; `acc` and `cnt` clear on that same edge.
- **Beat acceptance:** a beat is accepted only when `in_valid && in_ready` at a rising edge. `in_valid` with `in_ready`=0 has no effect.
- **Arithmetic:** unsigned, zero-extended to `SUM_WIDTH`. The sum of `NUM` max operands fits exactly, so overflow cannot occur. Wrap-around is modulo 2^`SUM_WIDTH` by construction.
- **Counter:** `cnt` is `$clog2(NUM+1)` bits and never exceeds `NUM`.
- **Order:** sum is order-independent. Operand index i corresponds to the i-th accepted beat, matching slice i of the packed bus.
- **Signal definitions:** `busy` = (state==`ACCUM`) || (state==`DONE`).
- **Reset:** `rst` high at any edge, including mid-batch or while in `DONE` with the output not yet taken, forces `IDLE`, `acc`=0, `cnt`=0. Partial batches are discarded.
- **Output values:** `out_sum` outside `DONE` is driven as 0.

## Timing
- **Reset values:** `in_ready`=1, `out_valid`=0, `out_sum`=0, `busy`=0.
- **Latency:** `out_valid` rises the cycle after the edge accepting the `NUM`-th beat.
- **Throughput:** minimum `NUM`+1 cycles per batch, i.e. `NUM` beats plus one `DONE` cycle when `out_ready` is held high.
- **Stalls:** `in_valid` gaps stall accumulation without limit. `out_ready` low holds `DONE` and `out_sum` indefinitely.
- **Registration:** `in_ready` and `out_valid` are registered, state-derived signals with no combinational path from `in_valid` or `out_ready`.
- **Simultaneous events in `DONE`:** `in_valid` together with the `out_ready` handshake — the beat is not accepted (`in_ready`=0). It is accepted the following cycle in `IDLE`.

## Structure
- **Package `adder1_pkg`:** state enum `adder1_state_e` {`IDLE`, `ACCUM`, `DONE`}; function `sum_width(width, num)` returning `width + $clog2(num)`. Shared with the chain adder's testbench.
- **Sub-module `adder1_acc_dp`:** `acc` register, adder, `cnt` register, with `clear`/`load` controls from the FSM. The top level holds the FSM and handshake only.
- **Total size:** approximately 150–250 RTL lines.

## Test plan
- **Basic batch:** `WIDTH`=8, `NUM`=4, beats 1, 2, 3, 4 back-to-back, `out_ready`=1 -> `out_valid` one cycle after the 4th beat with `out_sum`=10, then `IDLE`.
- **Max operands:** `WIDTH`=8, `NUM`=4, four beats of 0xFF -> `out_sum`=0x3FC (10 bits) with no truncation. With `NUM`=16, `WIDTH`=32, all 0xFFFFFFFF -> `out_sum`=0xFFFFFFFF0.
- **Backpressure and gaps:** `in_valid` toggling 1010…, `out_ready`=0 for 5 cycles after completion -> `out_sum` stable and `in_ready`=0 throughout; sum equals the reference chain-adder result on the same operands.
- **Reset mid-batch:** after 2 of 4 beats (values 7, 9), assert `rst` one cycle -> `busy`=0, `acc` cleared. The next batch 1, 1, 1, 1 yields `out_sum`=4.
- **`NUM`=1 corner:** single beat 0x5A -> `out_valid` next cycle with `out_sum`=0x5A. Back-to-back batches with `in_valid` held high -> one `IDLE` cycle between results, no lost or duplicated beats.
- **Random CEC:** 1000 random batches compared against the chain adder fed the same packed operands -> zero mismatches.

Source files
------------

// File: rtl/adder1_pkg.sv
// adder1_pkg: types and helpers shared by the sequential operand adder and
// the chain adder's bench.
//   adder1_state_e : FSM states of adder1_seq
//   sum_width()    : result width that holds the sum of num width-bit operands
package adder1_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } adder1_state_e;

    function automatic int sum_width(input int width, input int num);
        return width + $clog2(num);
    endfunction

endpackage

// File: rtl/adder1_acc_dp.sv
// adder1_acc_dp: accumulator datapath for adder1_seq.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : zero acc and cnt on this edge (takes priority over load)
//   load      : add in_data (zero-extended) into acc and bump cnt
//   in_data   : operand
//   acc       : running sum
//   cnt       : operands accumulated in the current batch
module adder1_acc_dp #(
    parameter int WIDTH     = 32,
    parameter int SUM_WIDTH = 36,
    parameter int CNT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 load,
    input  logic [WIDTH-1:0]     in_data,
    output logic [SUM_WIDTH-1:0] acc,
    output logic [CNT_WIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= acc + SUM_WIDTH'(in_data);
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/adder1_seq.sv
// adder1_seq: sums a batch of NUM unsigned operands received one per accepted
// beat and presents the result on a valid/ready output.
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : operand offered        in_ready : operand can be accepted
//   in_data   : operand (unsigned)
//   out_valid : out_sum holds a result out_ready: downstream takes the result
//   out_sum   : batch sum, 0 when no result is pending
//   busy      : batch in progress or result not yet delivered
module adder1_seq
    import adder1_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NUM       = 16,
    parameter int SUM_WIDTH = sum_width(WIDTH, NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SUM_WIDTH-1:0] out_sum,
    output logic                 busy
);

    localparam int CNT_WIDTH = $clog2(NUM + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM - 1);

    adder1_state_e state_q, state_d;

    logic                 load;
    logic                 clear;
    logic                 last_beat;
    logic [SUM_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] cnt;

    // Handshake outputs decode only the state register, so they carry no
    // combinational path from in_valid or out_ready.
    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = out_valid ? acc : '0;

    assign load      = in_valid && in_ready;
    assign clear     = out_valid && out_ready;
    // cnt is 0 in IDLE, so with NUM==1 the first beat is already the last.
    assign last_beat = (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = last_beat ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (load && last_beat) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    adder1_acc_dp #(
        .WIDTH     (WIDTH),
        .SUM_WIDTH (SUM_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_dp (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .load    (load),
        .in_data (in_data),
        .acc     (acc),
        .cnt     (cnt)
    );

endmodule
